// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared fetch-stage definitions (FSM encodings, NOP word, saturating increment)
package if_stage_pkg;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_REQ  = 2'd1,
        IF_WAIT = 2'd2,
        IF_HOLD = 2'd3
    } if_state_e;

    localparam logic [15:0] NOP_INSTR = 16'h0000;

    function automatic logic [15:0] sat_inc(input logic [15:0] c, input logic en);
        return (en && c != 16'hFFFF) ? c + 16'd1 : c;
    endfunction

endpackage

// File: rtl/if_stage.sv
// if_stage: instruction fetch FSM, PC owner and IF/ID register; IF_PERF_CNT_EN adds perf counters
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_INC   = 16'h0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [15:0] imem_rdata,
    output logic [15:0] id_instr,
    output logic [15:0] id_pc,
    output logic        id_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [15:0] perf_fetch_cnt,
    output logic [15:0] perf_bubble_cnt,
    output logic [15:0] perf_drop_cnt
`endif
);

    if_state_e   state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] id_instr_q, id_instr_d;
    logic [15:0] id_pc_q, id_pc_d;
    logic        id_valid_q, id_valid_d;
    logic        drop_q, drop_d;
    logic [15:0] hold_instr_q, hold_instr_d;
    logic [15:0] hold_pc_q, hold_pc_d;
    logic        load_new;
    logic [15:0] new_instr, new_pc;
    logic        keep_wait;

    assign imem_req  = state_q == IF_REQ;
    assign imem_addr = pc_q;
    assign id_instr  = id_instr_q;
    assign id_pc     = id_pc_q;
    assign id_valid  = id_valid_q;

    // A response that is still owed after a redirect must be swallowed, so stay in WAIT with drop set
    assign keep_wait = (state_q == IF_WAIT && !imem_rvalid) || (state_q == IF_REQ && imem_gnt);

    // Next-state: fetch sequencing, single-entry hold buffer, IF/ID load, redirect override
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drop_d       = drop_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        id_instr_d   = id_instr_q;
        id_pc_d      = id_pc_q;
        id_valid_d   = id_valid_q;
        load_new     = 1'b0;
        new_instr    = NOP_INSTR;
        new_pc       = pc_q;
        case (state_q)
            IF_IDLE: state_d = IF_REQ;
            IF_REQ:  state_d = imem_gnt ? IF_WAIT : IF_REQ;
            IF_WAIT: begin
                if (imem_rvalid && drop_q) begin
                    drop_d  = 1'b0;
                    state_d = IF_REQ;
                end else if (imem_rvalid && !stall) begin
                    load_new  = 1'b1;
                    new_instr = imem_rdata;
                    pc_d      = pc_q + PC_INC;
                    state_d   = IF_REQ;
                end else if (imem_rvalid) begin
                    hold_instr_d = imem_rdata;
                    hold_pc_d    = pc_q;
                    pc_d         = pc_q + PC_INC;
                    state_d      = IF_HOLD;
                end
            end
            IF_HOLD: begin
                if (!stall) begin
                    load_new  = 1'b1;
                    new_instr = hold_instr_q;
                    new_pc    = hold_pc_q;
                    state_d   = IF_REQ;
                end
            end
            default: state_d = IF_IDLE;
        endcase
        if (!stall) begin
            id_instr_d = load_new ? new_instr : NOP_INSTR;
            id_pc_d    = load_new ? new_pc : pc_q;
            id_valid_d = load_new;
        end
        if (redirect) begin
            pc_d       = redirect_pc;
            id_instr_d = NOP_INSTR;
            id_pc_d    = pc_q;
            id_valid_d = 1'b0;
            state_d    = keep_wait ? IF_WAIT : IF_REQ;
            drop_d     = keep_wait;
        end
    end

    // State and pipeline registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IF_IDLE;
            pc_q         <= RESET_PC;
            drop_q       <= 1'b0;
            hold_instr_q <= NOP_INSTR;
            hold_pc_q    <= 16'h0000;
            id_instr_q   <= NOP_INSTR;
            id_pc_q      <= 16'h0000;
            id_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drop_q       <= drop_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            id_instr_q   <= id_instr_d;
            id_pc_q      <= id_pc_d;
            id_valid_q   <= id_valid_d;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [15:0] perf_fetch_q, perf_fetch_d;
    logic [15:0] perf_bubble_q, perf_bubble_d;
    logic [15:0] perf_drop_q, perf_drop_d;
    logic        if_load;

    assign if_load         = redirect || !stall;
    assign perf_fetch_cnt  = perf_fetch_q;
    assign perf_bubble_cnt = perf_bubble_q;
    assign perf_drop_cnt   = perf_drop_q;

    // Saturating event counters: IF/ID real loads, IF/ID bubble loads, discarded responses
    always_comb begin
        perf_fetch_d  = sat_inc(perf_fetch_q, if_load && id_valid_d);
        perf_bubble_d = sat_inc(perf_bubble_q, if_load && !id_valid_d);
        perf_drop_d   = sat_inc(perf_drop_q, state_q == IF_WAIT && imem_rvalid && (drop_q || redirect));
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_q  <= 16'h0000;
            perf_bubble_q <= 16'h0000;
            perf_drop_q   <= 16'h0000;
        end else begin
            perf_fetch_q  <= perf_fetch_d;
            perf_bubble_q <= perf_bubble_d;
            perf_drop_q   <= perf_drop_d;
        end
    end
`endif

endmodule
